dram_rr_arbiter: RTL

- Parametrised shared-DRAM front end for the N-core matrix-multiplication array: N cores issue single-word DRAM reads/writes; a round-robin arbiter serialises them onto one DRAM port.
- Returns read data to the requesting core only, with a configurable DRAM read latency.
- Collects each core's end_process into one sticky all_done, so the top level knows when the whole array has finished.

---
 rtl/dram_rr_arbiter_if.sv | 33 +++
 rtl/dram_rr_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dram_rr_arbiter_if.sv
// Bundle of core-side and DRAM-side signals shared by the arbiter and its users.
interface dram_rr_arbiter_if #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        wr_en;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        core_done;
  logic [N_CORES-1:0]        grant;
  logic [N_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wrEn;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic                      all_done;

  // Arbiter side.
  modport slave (
    input  req, wr_en, addr, wdata, core_done, mem_rdata,
    output grant, rvalid, rdata, mem_addr, mem_wdata, mem_wrEn, busy, all_done
  );

  // Cores plus DRAM side.
  modport master (
    output req, wr_en, addr, wdata, core_done, mem_rdata,
    input  grant, rvalid, rdata, mem_addr, mem_wdata, mem_wrEn, busy, all_done
  );
endinterface

// File: rtl/dram_rr_arbiter.sv
// Round-robin front end serialising single-word core reads/writes onto one DRAM port,
// returning read data to the requester and aggregating per-core done flags.
module dram_rr_arbiter #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  dram_rr_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_CORES-1:0]  grant_q, grant_d;
  logic [N_CORES-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [N_CORES-1:0]  done_mask_q, done_mask_d;
  logic                all_done_q, all_done_d;

  logic [IdxW-1:0]     scan_idx;
  logic [IdxW-1:0]     pick;
  logic                pick_vld;

  // Round-robin pick: offsets are scanned high-to-low so the nearest requester after
  // the last winner is the one left standing.
  always_comb begin
    scan_idx = '0;
    pick     = last_q;
    pick_vld = 1'b0;
    for (int k = int'(N_CORES); k >= 1; k--) begin
      scan_idx = IdxW'((32'(last_q) + 32'(k)) % N_CORES);
      if (bus.req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(N_CORES - 1);
      sel_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      done_mask_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      done_mask_q <= done_mask_d;
      all_done_q  <= all_done_d;
    end
  end

  // Next-state: transaction sequencing plus sticky done aggregation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_en_d = 1'b0;
    done_mask_d = done_mask_q | bus.core_done;
    all_done_d  = &done_mask_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d        = StIssue;
          last_d         = pick;
          sel_d          = pick;
          grant_d[pick]  = 1'b1;
          mem_addr_d     = bus.addr[pick*ADDR_W +: ADDR_W];
          mem_wdata_d    = bus.wdata[pick*DATA_W +: DATA_W];
          mem_wr_en_d    = bus.wr_en[pick];
        end
      end
      StIssue: begin
        // mem_wr_en_q still carries the captured direction during the issue cycle.
        if (mem_wr_en_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = CntW'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d         = StResp;
          rdata_d         = bus.mem_rdata;
          rvalid_d[sel_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: busy decodes directly from state, the rest come straight from flops.
  always_comb begin
    bus.busy = (state_q != StIdle);
  end

  assign bus.grant     = grant_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wrEn  = mem_wr_en_q;
  assign bus.all_done  = all_done_q;

endmodule
